button_event_classifier: RTL and testbench

- Upstream front end for the stopwatch control FSM, one instance per push button (A and B).
- Synchronises and debounces a raw active-low button and measures the hold time.
- Emits one-cycle short-press, long-press and release events that the stopwatch uses as mode and lap commands.
- Replaces the ad-hoc per-button sampling and counting logic with one verified, parameterised stage.

---
 rtl/button_event_classifier.sv | 172 +++++++++++++++++
 tb/tb_button_event_classifier.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_classifier.sv
// Purpose: synchronise, debounce and time one raw push button; emit short/long/release events.
// Latency: raw edge -> pressed in 2 sync cycles + up to STABLE_SAMPLES*SAMPLE_CYCLES; events registered on that same edge.
// Backpressure: none; events are single-cycle pulses that the consumer must sample when they occur.
module button_event_classifier #(
    parameter int   SAMPLE_CYCLES  = 500000,
    parameter int   STABLE_SAMPLES = 2,
    parameter int   LONG_CYCLES    = 50000000,
    parameter logic PRESSED_LEVEL  = 1'b0
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        btn_raw,
    output logic        pressed,
    output logic        short_press,
    output logic        long_press,
    // "release" is a reserved word, so the release pulse is named release_event
    output logic        release_event,
    output logic [31:0] hold_cycles
);

    localparam int              TICK_W         = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(SAMPLE_CYCLES - 1);
    localparam logic [3:0]      STABLE_N       = 4'(STABLE_SAMPLES);
    localparam logic [31:0]     LONG_N         = 32'(LONG_CYCLES);
    localparam logic            RELEASED_LEVEL = ~PRESSED_LEVEL;

    typedef enum logic [1:0] {
        IDLE,
        TIMING,
        LONG
    } state_t;

    logic              sync_meta;
    logic              s_btn;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              deb_level;
    logic              deb_nxt;
    logic [3:0]        agree_cnt;
    logic [3:0]        agree_nxt;
    logic              pressed_nxt;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       hold_nxt;
    logic              short_nxt;
    logic              long_nxt;
    logic              release_nxt;

    // Two-flop synchroniser; reset loads the released level so no false press appears.
    always_ff @(posedge clock) begin
        if (rst) begin
            sync_meta <= RELEASED_LEVEL;
            s_btn     <= RELEASED_LEVEL;
        end else begin
            sync_meta <= btn_raw;
            s_btn     <= sync_meta;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running sample divider, 0..SAMPLE_CYCLES-1.
    always_ff @(posedge clock) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Debounce: flip the level after STABLE_SAMPLES consecutive disagreeing samples.
    always_comb begin
        deb_nxt   = deb_level;
        agree_nxt = agree_cnt;
        if (tick) begin
            if (s_btn != deb_level) begin
                if (agree_cnt + 4'd1 >= STABLE_N) begin
                    deb_nxt   = s_btn;
                    agree_nxt = '0;
                end else begin
                    agree_nxt = agree_cnt + 4'd1;
                end
            end else begin
                agree_nxt = '0;
            end
        end
    end

    // Debounced level and agreement counter registers.
    always_ff @(posedge clock) begin
        if (rst) begin
            deb_level <= RELEASED_LEVEL;
            agree_cnt <= '0;
        end else begin
            deb_level <= deb_nxt;
            agree_cnt <= agree_nxt;
        end
    end

    assign pressed     = (deb_level == PRESSED_LEVEL);
    // The FSM looks at the level the debouncer is about to register, so events and
    // hold_cycles change on the same edge as pressed.
    assign pressed_nxt = (deb_nxt == PRESSED_LEVEL);

    // Hold timing FSM: next state, hold counter and event pulses.
    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cycles;
        short_nxt   = 1'b0;
        long_nxt    = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pressed_nxt) begin
                    state_nxt = TIMING;
                    hold_nxt  = 32'd1;
                end else begin
                    hold_nxt  = '0;
                end
            end
            TIMING: begin
                // Release is checked first so it wins over a coincident threshold.
                if (!pressed_nxt) begin
                    state_nxt   = IDLE;
                    hold_nxt    = '0;
                    short_nxt   = 1'b1;
                    release_nxt = 1'b1;
                end else if (hold_cycles + 32'd1 >= LONG_N) begin
                    state_nxt   = LONG;
                    hold_nxt    = LONG_N;
                    long_nxt    = 1'b1;
                end else begin
                    hold_nxt    = hold_cycles + 32'd1;
                end
            end
            LONG: begin
                if (!pressed_nxt) begin
                    state_nxt   = IDLE;
                    hold_nxt    = '0;
                    release_nxt = 1'b1;
                end else begin
                    hold_nxt    = LONG_N;
                end
            end
            default: begin
                state_nxt = IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

    // FSM state, hold counter and registered event outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= IDLE;
            hold_cycles   <= '0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            release_event <= 1'b0;
        end else begin
            state         <= state_nxt;
            hold_cycles   <= hold_nxt;
            short_press   <= short_nxt;
            long_press    <= long_nxt;
            release_event <= release_nxt;
        end
    end

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier with SAMPLE_CYCLES=4, STABLE_SAMPLES=2.
// E in the comments counts non-reset clock edges since reset; sample ticks land on E = 4k.
// A second instance uses LONG_CYCLES=41 so a debounced release (always on a tick edge) can coincide with the threshold.
module tb_button_event_classifier;

    logic        clock;
    logic        rst;
    logic        btn_raw;

    logic        pressed,   short_press,   long_press,   release_event;
    logic [31:0] hold_cycles;
    logic        pressed_b, short_press_b, long_press_b, release_event_b;
    logic [31:0] hold_cycles_b;

    int n_vec  = 0;
    int n_fail = 0;

    int   n_sp   = 0;
    int   n_lp   = 0;
    int   n_rel  = 0;
    int   n_excl = 0;
    int   n_rise = 0;
    logic pressed_q = 1'b0;

    button_event_classifier #(
        .SAMPLE_CYCLES (4),
        .STABLE_SAMPLES(2),
        .LONG_CYCLES   (40),
        .PRESSED_LEVEL (1'b0)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .pressed      (pressed),
        .short_press  (short_press),
        .long_press   (long_press),
        .release_event(release_event),
        .hold_cycles  (hold_cycles)
    );

    button_event_classifier #(
        .SAMPLE_CYCLES (4),
        .STABLE_SAMPLES(2),
        .LONG_CYCLES   (41),
        .PRESSED_LEVEL (1'b0)
    ) dut_b (
        .clock        (clock),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .pressed      (pressed_b),
        .short_press  (short_press_b),
        .long_press   (long_press_b),
        .release_event(release_event_b),
        .hold_cycles  (hold_cycles_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse accounting for the main instance, sampled on the falling edge.
    always @(negedge clock) begin
        if (short_press)   n_sp++;
        if (long_press)    n_lp++;
        if (release_event) n_rel++;
        if (long_press && (short_press || release_event)) n_excl++;
        if (pressed && !pressed_q) n_rise++;
        pressed_q = pressed;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 1'b1;
        step(3);                                         // E=0
        chk_b("rst_pressed", pressed, 1'b0);
        chk_b("rst_short",   short_press, 1'b0);
        chk_b("rst_long",    long_press, 1'b0);
        chk_b("rst_release", release_event, 1'b0);
        chk_n("rst_hold",    hold_cycles, 0);
        rst = 1'b0;

        // Idle for 100 cycles
        step(100);                                       // E=100
        chk_b("idle_pressed", pressed, 1'b0);
        chk_n("idle_events",  n_sp + n_lp + n_rel, 0);
        chk_n("idle_hold",    hold_cycles, 0);

        // Short press: low for 20 cycles
        btn_raw = 1'b0;
        step(7);                                         // E=107
        chk_b("sp_not_yet", pressed, 1'b0);
        step(1);                                         // E=108
        chk_b("sp_pressed", pressed, 1'b1);
        chk_n("sp_hold1",   hold_cycles, 1);
        step(12);                                        // E=120
        chk_n("sp_hold13",  hold_cycles, 13);
        btn_raw = 1'b1;
        step(7);                                         // E=127
        chk_b("sp_still_held", pressed, 1'b1);
        chk_n("sp_hold20",     hold_cycles, 20);
        step(1);                                         // E=128
        chk_b("sp_short",   short_press, 1'b1);
        chk_b("sp_release", release_event, 1'b1);
        chk_b("sp_nolong",  long_press, 1'b0);
        chk_b("sp_up",      pressed, 1'b0);
        chk_n("sp_hold0",   hold_cycles, 0);
        step(1);                                         // E=129
        chk_b("sp_short_1cyc",   short_press, 1'b0);
        chk_b("sp_release_1cyc", release_event, 1'b0);
        step(11);                                        // E=140
        chk_n("sp_cnt_short", n_sp, 1);
        chk_n("sp_cnt_rel",   n_rel, 1);
        chk_n("sp_cnt_long",  n_lp, 0);

        // Long press: low for 100 cycles
        btn_raw = 1'b0;
        step(8);                                         // E=148
        chk_b("lp_pressed", pressed, 1'b1);
        chk_n("lp_hold1",   hold_cycles, 1);
        step(38);                                        // E=186
        chk_n("lp_hold39",  hold_cycles, 39);
        chk_b("lp_not_yet", long_press, 1'b0);
        step(1);                                         // E=187
        chk_b("lp_long",    long_press, 1'b1);
        chk_n("lp_hold40",  hold_cycles, 40);
        step(1);                                         // E=188
        chk_b("lp_long_1cyc", long_press, 1'b0);
        chk_n("lp_sat",       hold_cycles, 40);
        step(52);                                        // E=240
        chk_n("lp_sat_late",  hold_cycles, 40);
        chk_n("lp_cnt_long",  n_lp, 1);
        chk_n("lp_b_sat41",   hold_cycles_b, 41);
        btn_raw = 1'b1;
        step(7);                                         // E=247
        chk_b("lp_still_held", pressed, 1'b1);
        step(1);                                         // E=248
        chk_b("lp_release", release_event, 1'b1);
        chk_b("lp_noshort", short_press, 1'b0);
        chk_n("lp_hold0",   hold_cycles, 0);
        step(12);                                        // E=260
        chk_n("lp_cnt_short", n_sp, 1);
        chk_n("lp_cnt_rel",   n_rel, 2);
        chk_n("lp_cnt_long",  n_lp, 1);

        // Glitches: 3 low / 5 high, ten times
        for (int g = 0; g < 10; g++) begin
            btn_raw = 1'b0;
            step(3);
            btn_raw = 1'b1;
            step(5);
        end
        step(20);                                        // E=360
        chk_b("gl_pressed", pressed, 1'b0);
        chk_n("gl_rises",   n_rise, 2);
        chk_n("gl_events",  n_sp + n_lp + n_rel, 4);

        // Release lands on the threshold edge of dut_b (LONG=41)
        btn_raw = 1'b0;
        step(8);                                         // E=368
        chk_n("co_b_hold1",  hold_cycles_b, 1);
        step(32);                                        // E=400
        chk_n("co_b_hold33", hold_cycles_b, 33);
        btn_raw = 1'b1;
        step(7);                                         // E=407
        chk_n("co_b_hold40", hold_cycles_b, 40);
        chk_b("co_b_nolong", long_press_b, 1'b0);
        chk_b("co_a_long",   long_press, 1'b1);
        step(1);                                         // E=408
        chk_b("co_b_short",   short_press_b, 1'b1);
        chk_b("co_b_release", release_event_b, 1'b1);
        chk_b("co_b_long0",   long_press_b, 1'b0);
        chk_n("co_b_hold0",   hold_cycles_b, 0);
        chk_b("co_a_release", release_event, 1'b1);
        chk_b("co_a_noshort", short_press, 1'b0);
        step(12);                                        // E=420

        // Reset while held at hold_cycles=25
        btn_raw = 1'b0;
        step(8);                                         // E=428
        chk_n("rh_hold1",  hold_cycles, 1);
        step(24);                                        // E=452
        chk_n("rh_hold25", hold_cycles, 25);
        rst = 1'b1;
        step(1);                                         // E=453, reset edge
        chk_b("rh_pressed", pressed, 1'b0);
        chk_n("rh_hold0",   hold_cycles, 0);
        chk_b("rh_short",   short_press, 1'b0);
        chk_b("rh_long",    long_press, 1'b0);
        chk_b("rh_release", release_event, 1'b0);
        rst = 1'b0;
        step(7);                                         // E=460
        chk_b("rh_not_yet", pressed, 1'b0);
        chk_n("rh_hold_z",  hold_cycles, 0);
        step(1);                                         // E=461
        chk_b("rh_repressed", pressed, 1'b1);
        chk_n("rh_restart1",  hold_cycles, 1);
        chk_n("rh_cnt_short", n_sp, 1);
        chk_n("rh_cnt_long",  n_lp, 2);
        chk_n("rh_cnt_rel",   n_rel, 3);
        btn_raw = 1'b1;
        step(20);                                        // E=481
        chk_n("end_cnt_short", n_sp, 2);
        chk_n("end_cnt_rel",   n_rel, 4);
        chk_n("end_cnt_long",  n_lp, 2);
        chk_n("end_exclusive", n_excl, 0);
        chk_n("end_hold",      hold_cycles, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
